// File: rtl/shift_add_multiplier_ctrl.sv
// Control unit and X/A/B register file for an 8x8 signed add-shift multiplier.
// The 9-bit adder/subtractor is external; the product is {A,B} with X as the sign extension.
module shift_add_multiplier_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH:0]   add_sum,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_sign,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Xval,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_cnt;
    logic [2:0]       w_next_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_m;
    logic             r_x;
    logic             w_last_add;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // NOTE: defaults at the top of the comb block keep every path assigned, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (!ClearA_LoadB && Run) begin
                    w_next_state = ST_ADD;
                    w_next_cnt   = '0;
                end
            end
            ST_ADD:   w_next_state = ST_SHIFT;
            ST_SHIFT: begin
                if (r_cnt == 3'd7) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_ADD;
                    w_next_cnt   = r_cnt + 3'd1;
                end
            end
            ST_DONE: begin
                if (!Run) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: a load in IDLE/DONE beats a start; busy states ignore ClearA_LoadB and S.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_a <= '0;
            r_b <= '0;
            r_m <= '0;
            r_x <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (ClearA_LoadB) begin
                        r_a <= '0;
                        r_x <= 1'b0;
                        r_b <= S;
                    end else if (r_state == ST_IDLE && Run) begin
                        r_m <= S;
                        r_a <= '0;
                        r_x <= 1'b0;
                    end
                end
                ST_ADD: begin
                    if (r_b[0]) {r_x, r_a} <= add_sum;
                end
                ST_SHIFT: {r_x, r_a, r_b} <= {r_x, r_x, r_a, r_b[WIDTH-1:1]};
                default: ;
            endcase
        end
    end

    // The final iteration subtracts: bit 7 of a signed multiplier carries negative weight.
    always_comb begin
        w_last_add = (r_state == ST_ADD) && (r_cnt == 3'd7);
        add_sign   = !w_last_add;
        busy       = (r_state == ST_ADD) || (r_state == ST_SHIFT);
        done       = (r_state == ST_DONE);
    end

    assign add_a = r_a;
    assign add_b = r_m;
    assign Aval  = r_a;
    assign Bval  = r_b;
    assign Xval  = r_x;

endmodule

// File: tb/tb_shift_add_multiplier_ctrl.sv
// Bench for shift_add_multiplier_ctrl: models the external 9-bit adder and checks
// table-driven signed products plus reset, hold-in-DONE and ignored-load sequences.
module tb_shift_add_multiplier_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] S;
    logic [8:0] add_sum;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_sign;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       Xval;
    logic       busy;
    logic       done;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [7:0]  b_load;
        logic [7:0]  s_val;
        logic [15:0] exp_ab;
        logic        exp_x;
    } vec_t;

    vec_t vecs[9];

    shift_add_multiplier_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .S            (S),
        .add_sum      (add_sum),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_sign     (add_sign),
        .Aval         (Aval),
        .Bval         (Bval),
        .Xval         (Xval),
        .busy         (busy),
        .done         (done)
    );

    always #5 Clk = ~Clk;

    // External adder/subtractor: 9-bit sign-extended result.
    always_comb begin
        if (add_sign) add_sum = {add_a[7], add_a} + {add_b[7], add_b};
        else          add_sum = {add_a[7], add_a} - {add_b[7], add_b};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic load_b(input logic [7:0] val);
        ClearA_LoadB = 1'b1;
        S = val;
        step();
        ClearA_LoadB = 1'b0;
    endtask

    // Starts a multiply and counts edges (start edge included) until done; optionally
    // pulses ClearA_LoadB for one edge after edge pulse_at to prove it is ignored.
    task automatic run_mult(input logic [7:0] s_val, input int pulse_at, output int edges);
        Run = 1'b1;
        S = s_val;
        edges = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            edges = n;
            if (n == 1) S = 8'h5A;
            if (ClearA_LoadB) ClearA_LoadB = 1'b0;
            if (n == pulse_at) begin
                ClearA_LoadB = 1'b1;
                S = 8'hAA;
            end
            if (n == 13) check("add_sign_add6", add_sign, 1);
            if (n == 15) check("add_sign_add7", add_sign, 0);
            if (done) break;
        end
        ClearA_LoadB = 1'b0;
    endtask

    initial begin
        int edges;

        vecs[0] = '{8'h07, 8'h3B, 16'h019D, 1'b0};
        vecs[1] = '{8'hF9, 8'h3B, 16'hFE63, 1'b1};
        vecs[2] = '{8'hF9, 8'hC5, 16'h019D, 1'b0};
        vecs[3] = '{8'h80, 8'h80, 16'h4000, 1'b0};
        vecs[4] = '{8'h7F, 8'h7F, 16'h3F01, 1'b0};
        vecs[5] = '{8'h80, 8'h7F, 16'hC080, 1'b1};
        vecs[6] = '{8'h00, 8'h5A, 16'h0000, 1'b0};
        vecs[7] = '{8'h01, 8'h80, 16'hFF80, 1'b1};
        vecs[8] = '{8'hFF, 8'hFF, 16'h0001, 1'b0};

        Reset = 1'b1;
        Run = 1'b0;
        ClearA_LoadB = 1'b0;
        S = 8'h00;
        step();
        step();
        Reset = 1'b0;
        check("reset_a", Aval, 0);
        check("reset_b", Bval, 0);
        check("reset_busy_done", {busy, done}, 0);

        // Reset while idle after a load
        load_b(8'h55);
        check("load_b", Bval, 8'h55);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("reset_idle_b", Bval, 0);

        // Reset mid-run at ADD3
        load_b(8'hFF);
        Run = 1'b1;
        S = 8'h11;
        repeat (7) step();
        check("busy_at_add3", busy, 1);
        check("a_nonzero_at_add3", (Aval != 0), 1);
        Reset = 1'b1;
        Run = 1'b0;
        step();
        Reset = 1'b0;
        check("reset_mid_axb", {Xval, Aval, Bval}, 0);
        check("reset_mid_m", add_b, 0);
        check("reset_mid_busy_done", {busy, done}, 0);
        step();
        check("reset_mid_stays_idle", busy, 0);

        for (int i = 0; i < 9; i++) begin
            load_b(vecs[i].b_load);
            run_mult(vecs[i].s_val, 0, edges);
            check($sformatf("vec%0d_latency", i), edges, 17);
            check($sformatf("vec%0d_product", i), {Aval, Bval}, vecs[i].exp_ab);
            check($sformatf("vec%0d_x", i), Xval, vecs[i].exp_x);
            Run = 1'b0;
            step();
            check($sformatf("vec%0d_idle", i), {busy, done}, 0);
        end

        // Run held high in DONE: no restart; then a chained multiply of B=0x9D by 3
        load_b(8'h07);
        run_mult(8'h3B, 0, edges);
        check("hold_product", {Aval, Bval}, 16'h019D);
        repeat (5) step();
        check("hold_done", {busy, done}, 2'b01);
        check("hold_product_after", {Aval, Bval}, 16'h019D);
        Run = 1'b0;
        step();
        check("hold_release_idle", done, 0);
        run_mult(8'h03, 0, edges);
        check("chain_latency", edges, 17);
        check("chain_product", {Aval, Bval}, 16'hFED7);
        check("chain_x", Xval, 1);
        Run = 1'b0;
        step();

        // ClearA_LoadB pulsed at SHIFT2 is ignored
        load_b(8'h07);
        run_mult(8'h3B, 6, edges);
        check("pulse_latency", edges, 17);
        check("pulse_product", {Aval, Bval}, 16'h019D);
        Run = 1'b0;
        step();

        // Load and Run together in IDLE: load only
        ClearA_LoadB = 1'b1;
        Run = 1'b1;
        S = 8'h22;
        step();
        check("load_beats_run_b", Bval, 8'h22);
        check("load_beats_run_a", Aval, 0);
        check("load_beats_run_busy", busy, 0);
        ClearA_LoadB = 1'b0;
        Run = 1'b0;
        step();
        check("load_beats_run_idle", {busy, done}, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
